// File: rtl/config_pkg.sv
// Shared definitions for the configuration-mode controller: target codes,
// field counts per target and the controller FSM encoding.
package config_pkg;

  localparam logic [1:0] CONF_NONE  = 2'b00;
  localparam logic [1:0] CONF_HORA  = 2'b01;
  localparam logic [1:0] CONF_FECHA = 2'b10;
  localparam logic [1:0] CONF_TIMER = 2'b11;

  localparam int N_CAMPOS_HORA  = 3;
  localparam int N_CAMPOS_FECHA = 4;
  localparam int N_CAMPOS_TIMER = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } estado_t;

  // Index of the last field for a target; the cursor wraps around it.
  function automatic logic [1:0] ultimo_campo(input logic [1:0] modo);
    case (modo)
      CONF_FECHA: return 2'(N_CAMPOS_FECHA - 1);
      CONF_TIMER: return 2'(N_CAMPOS_TIMER - 1);
      default:    return 2'(N_CAMPOS_HORA - 1);
    endcase
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Idle-cycle counter for the edit session; flags the terminal count for one
// cycle unless a clear arrives in that same cycle.
module contador_timeout #(
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fin_cuenta
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    fin_cuenta = enable && !clear && (cnt_q == CNT_FIN);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = fin_cuenta ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/controlador_funcion_conf.sv
// Config-mode controller: turns debounced button pulses into the active
// config target, a field cursor and registered inc/dec/commit/timeout strobes.
module controlador_funcion_conf #(
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_conf,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  input  logic [1:0] sw_modo,
  output logic [1:0] funcion_conf,
  output logic [1:0] campo,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       en_config,
  output logic       commit_pulse,
  output logic       timeout_pulse
);

  import config_pkg::*;

  estado_t    estado_q, estado_d;
  logic [1:0] funcion_conf_q, funcion_conf_d;
  logic [1:0] campo_q, campo_d;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;
  logic       en_config_q, en_config_d;
  logic       commit_q, commit_d;
  logic       timeout_q, timeout_d;

  logic       algun_btn;
  logic       cnt_enable;
  logic       cnt_clear;
  logic       fin_cuenta;
  logic [1:0] ultimo;

  assign algun_btn  = btn_conf | btn_izq | btn_der | btn_arriba | btn_abajo;
  assign cnt_enable = (estado_q == ST_EDIT);
  assign cnt_clear  = !cnt_enable || algun_btn;

  contador_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_contador_timeout (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .enable     (cnt_enable),
    .fin_cuenta (fin_cuenta)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= ST_IDLE;
    end else begin
      estado_q <= estado_d;
    end
  end

  // A button in the terminal-count cycle keeps the session alive.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_IDLE: begin
        if (btn_conf && (sw_modo != CONF_NONE)) estado_d = ST_EDIT;
      end
      ST_EDIT: begin
        if (btn_conf)        estado_d = ST_COMMIT;
        else if (fin_cuenta) estado_d = ST_IDLE;
      end
      ST_COMMIT: estado_d = ST_IDLE;
      default:   estado_d = ST_IDLE;
    endcase
  end

  always_comb begin
    funcion_conf_d = CONF_NONE;
    campo_d        = '0;
    inc_d          = 1'b0;
    dec_d          = 1'b0;
    en_config_d    = 1'b0;
    commit_d       = 1'b0;
    timeout_d      = 1'b0;
    ultimo         = ultimo_campo(funcion_conf_q);
    case (estado_q)
      ST_IDLE: begin
        if (btn_conf && (sw_modo != CONF_NONE)) begin
          funcion_conf_d = sw_modo;
          en_config_d    = 1'b1;
        end
      end
      ST_EDIT: begin
        if (btn_conf) begin
          // Target stays selected through the commit cycle so CS remains valid.
          funcion_conf_d = funcion_conf_q;
          campo_d        = campo_q;
          en_config_d    = 1'b1;
          commit_d       = 1'b1;
        end else if (fin_cuenta) begin
          timeout_d = 1'b1;
        end else begin
          funcion_conf_d = funcion_conf_q;
          en_config_d    = 1'b1;
          campo_d        = campo_q;
          if (btn_der && !btn_izq) begin
            campo_d = (campo_q == ultimo) ? 2'd0 : campo_q + 2'd1;
          end else if (btn_izq && !btn_der) begin
            campo_d = (campo_q == 2'd0) ? ultimo : campo_q - 2'd1;
          end
          inc_d = btn_arriba && !btn_abajo;
          dec_d = btn_abajo && !btn_arriba;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      funcion_conf_q <= CONF_NONE;
      campo_q        <= '0;
      inc_q          <= 1'b0;
      dec_q          <= 1'b0;
      en_config_q    <= 1'b0;
      commit_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      funcion_conf_q <= funcion_conf_d;
      campo_q        <= campo_d;
      inc_q          <= inc_d;
      dec_q          <= dec_d;
      en_config_q    <= en_config_d;
      commit_q       <= commit_d;
      timeout_q      <= timeout_d;
    end
  end

  assign funcion_conf  = funcion_conf_q;
  assign campo         = campo_q;
  assign inc_pulse     = inc_q;
  assign dec_pulse     = dec_q;
  assign en_config     = en_config_q;
  assign commit_pulse  = commit_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_controlador_funcion_conf.sv
// Bench for controlador_funcion_conf: directed scenarios plus randomized
// button traffic checked against a cycle-level behavioural model.
module tb_controlador_funcion_conf;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_conf, btn_izq, btn_der, btn_arriba, btn_abajo;
  logic [1:0] sw_modo;
  logic [1:0] funcion_conf;
  logic [1:0] campo;
  logic       inc_pulse, dec_pulse, en_config, commit_pulse, timeout_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model of the controller's observable outputs.
  bit m_en, m_cp, m_inc, m_dec, m_to;
  int m_mode, m_campo, m_quiet;

  controlador_funcion_conf #(
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_conf      (btn_conf),
    .btn_izq       (btn_izq),
    .btn_der       (btn_der),
    .btn_arriba    (btn_arriba),
    .btn_abajo     (btn_abajo),
    .sw_modo       (sw_modo),
    .funcion_conf  (funcion_conf),
    .campo         (campo),
    .inc_pulse     (inc_pulse),
    .dec_pulse     (dec_pulse),
    .en_config     (en_config),
    .commit_pulse  (commit_pulse),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_cp = 0; m_inc = 0; m_dec = 0; m_to = 0;
    m_mode = 0; m_campo = 0; m_quiet = 0;
  endtask

  task automatic model_step();
    bit any;
    int n;
    any = btn_conf | btn_izq | btn_der | btn_arriba | btn_abajo;
    n   = (m_mode == 2) ? 4 : 3;
    if (!reset) begin
      model_reset();
    end else begin
      m_inc = 0; m_dec = 0; m_to = 0;
      if (m_cp) begin
        m_cp = 0; m_en = 0; m_mode = 0; m_campo = 0;
      end else if (!m_en) begin
        if (btn_conf && sw_modo != 2'd0) begin
          m_en = 1; m_mode = int'(sw_modo); m_campo = 0; m_quiet = 0;
        end
      end else if (btn_conf) begin
        m_cp = 1; m_quiet = 0;
      end else if (any) begin
        m_quiet = 0;
        if (btn_der && !btn_izq)      m_campo = (m_campo + 1) % n;
        else if (btn_izq && !btn_der) m_campo = (m_campo + n - 1) % n;
        m_inc = btn_arriba && !btn_abajo;
        m_dec = btn_abajo && !btn_arriba;
      end else if (m_quiet == TO - 1) begin
        m_en = 0; m_mode = 0; m_campo = 0; m_to = 1;
      end else begin
        m_quiet++;
      end
    end
  endtask

  task automatic check_all();
    chk("funcion_conf", funcion_conf, m_mode);
    chk("campo", campo, m_campo);
    chk("en_config", en_config, m_en);
    chk("inc_pulse", inc_pulse, m_inc);
    chk("dec_pulse", dec_pulse, m_dec);
    chk("commit_pulse", commit_pulse, m_cp);
    chk("timeout_pulse", timeout_pulse, m_to);
  endtask

  task automatic clr_btn();
    btn_conf = 0; btn_izq = 0; btn_der = 0; btn_arriba = 0; btn_abajo = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    clr_btn();
  endtask

  task automatic press(input bit c, input bit i, input bit d, input bit a, input bit b);
    btn_conf = c; btn_izq = i; btn_der = d; btn_arriba = a; btn_abajo = b;
    tick();
  endtask

  task automatic enter(input logic [1:0] modo);
    sw_modo = modo;
    press(1, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    sw_modo = 2'd0;
    clr_btn();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Fecha: four fields with wrap.
    enter(2'd2);
    chk("fecha_fc", funcion_conf, 2);
    chk("fecha_en", en_config, 1);
    press(0, 0, 1, 0, 0); chk("der_1", campo, 1);
    press(0, 0, 1, 0, 0); chk("der_2", campo, 2);
    press(0, 0, 1, 0, 0); chk("der_3", campo, 3);
    press(0, 0, 1, 0, 0); chk("der_wrap", campo, 0);
    press(1, 0, 0, 0, 0);
    tick();

    // Hora: left wrap, simultaneous left/right, strobes.
    enter(2'd1);
    press(0, 1, 0, 0, 0); chk("izq_wrap", campo, 2);
    press(0, 1, 1, 0, 0); chk("izq_der_hold", campo, 2);
    press(0, 0, 0, 1, 0); chk("inc_on", inc_pulse, 1);
    tick();               chk("inc_off", inc_pulse, 0);
    press(0, 0, 0, 1, 1); chk("both_inc", inc_pulse, 0);
    chk("both_dec", dec_pulse, 0);
    press(0, 0, 0, 0, 1); chk("dec_on", dec_pulse, 1);
    press(1, 0, 0, 0, 0);
    tick();

    // Timer: commit has priority over a same-cycle increment.
    enter(2'd3);
    press(1, 0, 0, 1, 0);
    chk("commit_no_inc", inc_pulse, 0);
    chk("commit_pulse", commit_pulse, 1);
    chk("commit_fc", funcion_conf, 3);
    tick();
    chk("after_commit_fc", funcion_conf, 0);
    chk("after_commit_pulse", commit_pulse, 0);

    // Timeout after TO quiet cycles.
    enter(2'd3);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_hold", en_config, 1);
    tick();
    chk("to_pulse", timeout_pulse, 1);
    chk("to_fc", funcion_conf, 0);
    chk("to_no_commit", commit_pulse, 0);
    tick();
    chk("to_one_cycle", timeout_pulse, 0);

    // A button at the terminal count restarts the count.
    enter(2'd1);
    for (int i = 0; i < TO - 1; i++) tick();
    press(0, 0, 1, 0, 0);
    chk("late_btn_en", en_config, 1);
    chk("late_btn_to", timeout_pulse, 0);
    chk("late_btn_campo", campo, 1);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("restart_hold", en_config, 1);
    tick();
    chk("restart_to", timeout_pulse, 1);
    tick();

    // Mode 00 does not enter EDIT.
    enter(2'd0);
    chk("mode0_en", en_config, 0);
    chk("mode0_fc", funcion_conf, 0);

    // Reset mid-EDIT with an increment pending.
    enter(2'd3);
    btn_arriba = 1'b1;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    chk("rst_no_inc", inc_pulse, 0);
    reset = 1'b1;
    press(0, 0, 0, 1, 0);
    chk("rst_idle_en", en_config, 0);
    chk("rst_idle_inc", inc_pulse, 0);

    // Randomized traffic with quiet stretches and occasional resets.
    for (int k = 0; k < 4000; k++) begin
      sw_modo = 2'($urandom_range(0, 3));
      if ((k % 300) < 260) begin
        btn_conf   = ($urandom_range(0, 15) == 0);
        btn_izq    = ($urandom_range(0, 5) == 0);
        btn_der    = ($urandom_range(0, 5) == 0);
        btn_arriba = ($urandom_range(0, 5) == 0);
        btn_abajo  = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
